// File: rtl/ysyx_210238_hazard_sb.sv
// Issue-stage hazard unit: per-operand bypass selection, load-use/scoreboard/WAW/capacity
// stalls, and a register scoreboard for long-latency producers that write back out of band.
module ysyx_210238_hazard_sb #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int NFWD     = 2,
  parameter int MAX_LONG = 4,
  parameter int SELW     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_issue_valid,
  input  logic [NSRC*AW-1:0]   i_src_addr,
  input  logic [NSRC-1:0]      i_src_en,
  input  logic [AW-1:0]        i_issue_rd,
  input  logic                 i_issue_rd_wen,
  input  logic                 i_issue_long,
  input  logic [NFWD*AW-1:0]   i_stage_rd,
  input  logic [NFWD-1:0]      i_stage_wen,
  input  logic [NFWD-1:0]      i_stage_fwd_ok,
  input  logic                 i_wb_valid,
  input  logic [AW-1:0]        i_wb_rd,
  output logic                 o_stall,
  output logic [NSRC*SELW-1:0] o_fwd_sel,
  output logic [NREG-1:0]      o_sb_busy,
  output logic                 o_long_full,
  output logic [31:0]          o_stall_cnt,
  output logic                 o_err
);

  localparam int CW    = $clog2(MAX_LONG + 1);
  localparam int NADDR = 1 << AW;
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_LONG);
  localparam logic [SELW-1:0] WB_SEL  = SELW'(NFWD + 1);

  logic [NREG-1:0]  sb_busy_q,   sb_busy_d;
  logic [CW-1:0]    long_cnt_q,  long_cnt_d;
  logic             long_full_q, long_full_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             err_q,       err_d;

  logic [NADDR-1:0]     busy_full;
  logic [NADDR-1:0]     sb_full_d;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 data_stall;
  logic [AW-1:0]        addr;
  logic                 hit;
  logic                 hit_ok;
  logic                 matched;
  logic [SELW-1:0]      hit_sel;
  logic                 waw_stall;
  logic                 cap_stall;
  logic                 stall;
  logic                 accept;
  logic                 sb_set;
  logic                 cnt_inc;
  logic                 cnt_dec;

  // Per-operand bypass resolution; the youngest matching stage overrides older ones.
  always_comb begin
    busy_full              = '0;
    busy_full[NREG-1:0]    = sb_busy_q;
    fwd_sel                = '0;
    data_stall             = 1'b0;
    addr                   = '0;
    hit                    = 1'b0;
    hit_ok                 = 1'b0;
    matched                = 1'b0;
    hit_sel                = '0;
    for (int s = 0; s < NSRC; s++) begin
      addr    = i_src_addr[s*AW +: AW];
      hit     = 1'b0;
      hit_ok  = 1'b0;
      hit_sel = '0;
      for (int k = NFWD - 1; k >= 0; k--) begin
        matched = i_stage_wen[k] && (i_stage_rd[k*AW +: AW] == addr);
        hit     = hit | matched;
        hit_ok  = matched ? i_stage_fwd_ok[k] : hit_ok;
        hit_sel = matched ? SELW'(k + 1) : hit_sel;
      end
      if (!i_src_en[s] || (addr == '0)) begin
        fwd_sel[s*SELW +: SELW] = '0;
      end else if (hit) begin
        fwd_sel[s*SELW +: SELW] = hit_ok ? hit_sel : '0;
        data_stall              = data_stall | !hit_ok;
      end else if (i_wb_valid && (i_wb_rd == addr)) begin
        fwd_sel[s*SELW +: SELW] = WB_SEL;
      end else begin
        fwd_sel[s*SELW +: SELW] = '0;
        data_stall              = data_stall | busy_full[addr];
      end
    end
  end

  // Stall decision and next-state for scoreboard, counters and error flag.
  always_comb begin
    waw_stall = i_issue_valid && i_issue_rd_wen && (i_issue_rd != '0) && busy_full[i_issue_rd]
                && !(i_wb_valid && (i_wb_rd == i_issue_rd));
    cap_stall = i_issue_valid && i_issue_long && (long_cnt_q == MAX_CNT) && !i_wb_valid;
    stall     = i_issue_valid && (data_stall || waw_stall || cap_stall);
    accept    = i_issue_valid && !stall;
    sb_set    = accept && i_issue_long && i_issue_rd_wen && (i_issue_rd != '0);
    cnt_inc   = accept && i_issue_long;
    cnt_dec   = i_wb_valid && (long_cnt_q != '0);

    // Clear first so a same-cycle set for a new producer wins.
    sb_full_d = busy_full;
    if (i_wb_valid) begin
      sb_full_d[i_wb_rd] = 1'b0;
    end else begin
      sb_full_d[i_wb_rd] = busy_full[i_wb_rd];
    end
    if (sb_set) begin
      sb_full_d[i_issue_rd] = 1'b1;
    end else begin
      sb_full_d[i_issue_rd] = sb_full_d[i_issue_rd];
    end
    sb_busy_d = sb_full_d[NREG-1:0];

    case ({cnt_inc, cnt_dec})
      2'b10:   long_cnt_d = (long_cnt_q == MAX_CNT) ? long_cnt_q : long_cnt_q + CW'(1);
      2'b01:   long_cnt_d = long_cnt_q - CW'(1);
      default: long_cnt_d = long_cnt_q;
    endcase
    long_full_d = (long_cnt_d == MAX_CNT);

    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    err_d = err_q | (i_wb_valid && ((long_cnt_q == '0) || !busy_full[i_wb_rd]));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb_busy_q   <= '0;
      long_cnt_q  <= '0;
      long_full_q <= 1'b0;
      stall_cnt_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      sb_busy_q   <= sb_busy_d;
      long_cnt_q  <= long_cnt_d;
      long_full_q <= long_full_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign o_stall     = stall;
  assign o_fwd_sel   = fwd_sel;
  assign o_sb_busy   = sb_busy_q;
  assign o_long_full = long_full_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_ysyx_210238_hazard_sb.sv
// Directed bench for the hazard/scoreboard unit with hand-computed expectations.
module tb_ysyx_210238_hazard_sb;
  logic        clock = 1'b0;
  logic        reset;
  logic        i_issue_valid;
  logic [9:0]  i_src_addr;
  logic [1:0]  i_src_en;
  logic [4:0]  i_issue_rd;
  logic        i_issue_rd_wen;
  logic        i_issue_long;
  logic [9:0]  i_stage_rd;
  logic [1:0]  i_stage_wen;
  logic [1:0]  i_stage_fwd_ok;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic        o_stall;
  logic [3:0]  o_fwd_sel;
  logic [31:0] o_sb_busy;
  logic        o_long_full;
  logic [31:0] o_stall_cnt;
  logic        o_err;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_210238_hazard_sb dut (
    .clock(clock), .reset(reset), .i_issue_valid(i_issue_valid), .i_src_addr(i_src_addr),
    .i_src_en(i_src_en), .i_issue_rd(i_issue_rd), .i_issue_rd_wen(i_issue_rd_wen),
    .i_issue_long(i_issue_long), .i_stage_rd(i_stage_rd), .i_stage_wen(i_stage_wen),
    .i_stage_fwd_ok(i_stage_fwd_ok), .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
    .o_stall(o_stall), .o_fwd_sel(o_fwd_sel), .o_sb_busy(o_sb_busy), .o_long_full(o_long_full),
    .o_stall_cnt(o_stall_cnt), .o_err(o_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    i_issue_valid  = 1'b0;
    i_src_addr     = 10'd0;
    i_src_en       = 2'b00;
    i_issue_rd     = 5'd0;
    i_issue_rd_wen = 1'b0;
    i_issue_long   = 1'b0;
    i_stage_rd     = 10'd0;
    i_stage_wen    = 2'b00;
    i_stage_fwd_ok = 2'b00;
    i_wb_valid     = 1'b0;
    i_wb_rd        = 5'd0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle();
    i_issue_valid  = 1'b1;
    i_issue_long   = 1'b1;
    i_issue_rd_wen = 1'b1;
    i_issue_rd     = rd;
    tick();
  endtask

  task automatic wb(input logic [4:0] rd);
    idle();
    i_wb_valid = 1'b1;
    i_wb_rd    = rd;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", o_sb_busy, 32'd0);
    chk("rst_full", {31'd0, o_long_full}, 32'd0);
    chk("rst_scnt", o_stall_cnt, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_sel", {28'd0, o_fwd_sel}, 32'd0);

    // 1: EX-to-EX forward
    i_issue_valid = 1'b1;
    i_stage_rd = {5'd0, 5'd5}; i_stage_wen = 2'b01; i_stage_fwd_ok = 2'b01;
    i_src_addr = {5'd0, 5'd5}; i_src_en = 2'b01;
    #1;
    chk("ex_fwd_sel", {28'd0, o_fwd_sel}, 32'h1);
    chk("ex_fwd_stall", {31'd0, o_stall}, 32'd0);
    tick();

    // 2: youngest stage not ready -> stall, then forward from stage 0
    idle();
    i_issue_valid = 1'b1;
    i_stage_rd = {5'd7, 5'd7}; i_stage_wen = 2'b11; i_stage_fwd_ok = 2'b10;
    i_src_addr = {5'd7, 5'd0}; i_src_en = 2'b10;
    #1;
    chk("lu_stall", {31'd0, o_stall}, 32'd1);
    tick();
    chk("lu_scnt", o_stall_cnt, 32'd1);
    i_stage_fwd_ok = 2'b11;
    #1;
    chk("lu_sel", {28'd0, o_fwd_sel}, 32'h4);
    chk("lu_nostall", {31'd0, o_stall}, 32'd0);
    tick();
    chk("lu_scnt_hold", o_stall_cnt, 32'd1);

    // 3: scoreboard stall resolved by wb bypass
    issue_long(5'd9);
    chk("sb_set", o_sb_busy, 32'h0000_0200);
    idle();
    i_issue_valid = 1'b1;
    i_src_addr = {5'd0, 5'd9}; i_src_en = 2'b01;
    #1;
    chk("sb_stall", {31'd0, o_stall}, 32'd1);
    i_wb_valid = 1'b1; i_wb_rd = 5'd9;
    #1;
    chk("wb_sel", {28'd0, o_fwd_sel}, 32'h3);
    chk("wb_nostall", {31'd0, o_stall}, 32'd0);
    tick();
    chk("sb_clr", o_sb_busy, 32'd0);
    chk("sb_err0", {31'd0, o_err}, 32'd0);

    // 4: capacity and WAW
    issue_long(5'd1);
    issue_long(5'd2);
    issue_long(5'd3);
    chk("cap_notfull", {31'd0, o_long_full}, 32'd0);
    issue_long(5'd4);
    chk("cap_full", {31'd0, o_long_full}, 32'd1);
    chk("cap_busy", o_sb_busy, 32'h0000_001E);
    i_issue_rd = 5'd10;
    #1;
    chk("cap_stall", {31'd0, o_stall}, 32'd1);
    i_wb_valid = 1'b1; i_wb_rd = 5'd1;
    #1;
    chk("cap_wb_ok", {31'd0, o_stall}, 32'd0);
    tick();
    chk("cap_busy2", o_sb_busy, 32'h0000_041C);
    chk("cap_still_full", {31'd0, o_long_full}, 32'd1);
    idle();
    i_issue_valid = 1'b1; i_issue_rd_wen = 1'b1; i_issue_rd = 5'd2;
    #1;
    chk("waw_stall", {31'd0, o_stall}, 32'd1);
    tick();
    chk("waw_scnt", o_stall_cnt, 32'd2);
    wb(5'd2);
    chk("drain_notfull", {31'd0, o_long_full}, 32'd0);
    wb(5'd3);
    wb(5'd4);
    wb(5'd10);
    idle();
    chk("drain_busy", o_sb_busy, 32'd0);
    chk("drain_err", {31'd0, o_err}, 32'd0);

    // 5: zero / disabled operands, long ops with rd=0
    i_issue_valid = 1'b1;
    i_stage_rd = 10'd0; i_stage_wen = 2'b11; i_stage_fwd_ok = 2'b01;
    i_src_addr = 10'd0; i_src_en = 2'b01;
    #1;
    chk("x0_sel", {28'd0, o_fwd_sel}, 32'd0);
    chk("x0_stall", {31'd0, o_stall}, 32'd0);
    i_src_addr = {5'd0, 5'd6}; i_src_en = 2'b00; i_stage_rd = {5'd6, 5'd6}; i_stage_fwd_ok = 2'b00;
    #1;
    chk("dis_sel", {28'd0, o_fwd_sel}, 32'd0);
    chk("dis_stall", {31'd0, o_stall}, 32'd0);
    issue_long(5'd0);
    chk("x0_busy", o_sb_busy, 32'd0);
    issue_long(5'd0);
    issue_long(5'd0);
    issue_long(5'd0);
    idle();
    chk("x0_full", {31'd0, o_long_full}, 32'd1);

    // 6: error flag and mid-operation reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r2_full", {31'd0, o_long_full}, 32'd0);
    wb(5'd5);
    chk("err_set", {31'd0, o_err}, 32'd1);
    idle();
    tick();
    chk("err_sticky", {31'd0, o_err}, 32'd1);
    issue_long(5'd11);
    issue_long(5'd12);
    issue_long(5'd13);
    chk("r3_busy", o_sb_busy, 32'h0000_3800);
    idle();
    i_issue_valid = 1'b1; i_src_addr = {5'd0, 5'd11}; i_src_en = 2'b01;
    tick();
    chk("r3_scnt", o_stall_cnt, 32'd1);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r3_busy0", o_sb_busy, 32'd0);
    chk("r3_full0", {31'd0, o_long_full}, 32'd0);
    chk("r3_err0", {31'd0, o_err}, 32'd0);
    chk("r3_scnt0", o_stall_cnt, 32'd0);
    issue_long(5'd0);
    issue_long(5'd0);
    issue_long(5'd0);
    chk("r3_cnt0", {31'd0, o_long_full}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
